// File: rtl/led_pkg.sv
// Shared types and helpers for the LED fade/PWM stage.
package led_pkg;

    // Per-channel fade state.
    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRise = 2'd1,
        StOn   = 2'd2,
        StFall = 2'd3
    } fade_state_e;

    // Largest duty value for a given PWM width.
    function automatic int unsigned duty_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: fade state machine, duty register and PWM compare.
module led_fade_chan
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                target,
    input  logic                tick,
    input  logic                fade_en,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_o,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(duty_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] DutyOne = PWM_BITS'(1);

    fade_state_e         state_q, state_d, dir;
    logic [PWM_BITS-1:0] duty_q, duty_d;

    // Next state/duty: the direction is resolved first so a tick in the same cycle uses it.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir     = state_q;
        if (!fade_en) begin
            state_d = target ? StOn : StOff;
            duty_d  = target ? DutyMax : '0;
        end else begin
            case (state_q)
                StOff:   dir = target ? StRise : StOff;
                StRise:  dir = target ? StRise : StFall;
                StOn:    dir = target ? StOn   : StFall;
                StFall:  dir = target ? StRise : StFall;
                default: dir = StOff;
            endcase
            state_d = dir;
            if (dir == StRise) begin
                if (tick && (duty_q != DutyMax)) begin
                    duty_d = duty_q + DutyOne;
                end
                if (duty_d == DutyMax) begin
                    state_d = StOn;
                end
            end else if (dir == StFall) begin
                if (tick && (duty_q != '0)) begin
                    duty_d = duty_q - DutyOne;
                end
                if (duty_d == '0) begin
                    state_d = StOff;
                end
            end
        end
    end

    // State, duty and registered LED drive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StOff;
            duty_q  <= '0;
            led_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            led_o   <= fade_en ? (pwm_cnt < duty_q) : target;
        end
    end

    assign ramping = (state_q == StRise) || (state_q == StFall);

endmodule

// File: rtl/led_fade_pwm.sv
// PWM LED fader: shared PWM counter and fade timebase feeding N_LED fade channels.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int unsigned N_LED         = 4,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned FADE_STEP_CYC = 39_062
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_LED-1:0] led_in,
    input  logic             fade_en,
    output logic [N_LED-1:0] led_out,
    output logic             busy
);

    localparam int unsigned StepW = (FADE_STEP_CYC > 1) ? $clog2(FADE_STEP_CYC) : 1;
    // PWM period is DUTY_MAX cycles so a full duty never drops low.
    localparam logic [PWM_BITS-1:0] PwmLast  = PWM_BITS'(duty_max(PWM_BITS) - 1);
    localparam logic [StepW-1:0]    StepLast = StepW'(FADE_STEP_CYC - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [StepW-1:0]    step_cnt_q;
    logic                tick;
    logic [N_LED-1:0]    ramping;

    assign tick = (step_cnt_q == StepLast);

    // Free-running PWM and fade-step counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            pwm_cnt_q  <= (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + PWM_BITS'(1);
            step_cnt_q <= tick ? '0 : step_cnt_q + StepW'(1);
        end
    end

    // Registered activity flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |ramping;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .target   (led_in[i]),
            .tick     (tick),
            .fade_en  (fade_en),
            .pwm_cnt  (pwm_cnt_q),
            .led_o    (led_out[i]),
            .ramping  (ramping[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a short PWM and fade timebase.
module tb_led_fade_pwm;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] led_in    = 4'h0;
    logic       fade_en   = 1'b1;
    logic [3:0] led_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    led_fade_pwm #(
        .N_LED        (4),
        .PWM_BITS     (4),
        .FADE_STEP_CYC(4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led_in   (led_in),
        .fade_en  (fade_en),
        .led_out  (led_out),
        .busy     (busy)
    );

    logic [3:0] duty0, duty1, duty3;
    assign duty0 = dut.g_chan[0].u_chan.duty_q;
    assign duty1 = dut.g_chan[1].u_chan.duty_q;
    assign duty3 = dut.g_chan[3].u_chan.duty_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reset with a given led_in; returns on the negedge where reset is released (edge count 0).
    task automatic apply_reset(input logic [3:0] pat);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        led_in    = pat;
        fade_en   = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int bad_duty, bad_led, bad_busy, bad_hi, highs, peak, exp_d0, exp_d1;

        // Reset held with all targets on: everything dark.
        sys_rst_n = 1'b0;
        led_in    = 4'hF;
        repeat (3) @(negedge sys_clk);
        check_eq("rst_led_out", 32'(led_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            check_eq("post_rst_dark", 32'(led_out), 32'd0);
            if (k == 3) check_eq("post_rst_busy", 32'(busy), 32'd1);
        end

        // Full rise on channel 0 with per-cycle PWM compare.
        apply_reset(4'h0);
        led_in   = 4'b0001;
        bad_duty = 0; bad_led = 0; bad_busy = 0; bad_hi = 0; highs = 0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge sys_clk);
            if (32'(duty0) != 32'(min_i(k / 4, 15))) bad_duty++;
            if (led_out[0] != (((k - 1) % 15) < min_i((k - 1) / 4, 15))) bad_led++;
            if (busy != ((k >= 2) && (k <= 60))) bad_busy++;
            if (led_out[3:1] != 3'b000) bad_hi++;
            if (k >= 62 && k <= 76 && led_out[0]) highs++;
            if (k == 2)  check_eq("rise_busy_start", 32'(busy), 32'd1);
            if (k == 4)  check_eq("rise_first_tick", 32'(duty0), 32'd1);
            if (k == 59) check_eq("rise_duty14", 32'(duty0), 32'd14);
            if (k == 60) check_eq("rise_duty15", 32'(duty0), 32'd15);
            if (k == 61) check_eq("rise_busy_end", 32'(busy), 32'd0);
        end
        check_eq("rise_duty_seq", 32'(bad_duty), 32'd0);
        check_eq("rise_pwm_cmp", 32'(bad_led), 32'd0);
        check_eq("rise_busy_seq", 32'(bad_busy), 32'd0);
        check_eq("rise_other_dark", 32'(bad_hi), 32'd0);
        check_eq("full_duty_highs", 32'(highs), 32'd15);

        // Reversal after five ticks.
        apply_reset(4'h0);
        led_in   = 4'b0001;
        bad_duty = 0; peak = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge sys_clk);
            if (k <= 20)     exp_d0 = k / 4;
            else if (k < 24) exp_d0 = 5;
            else             exp_d0 = max_i(5 - (k - 20) / 4, 0);
            if (32'(duty0) != 32'(exp_d0)) bad_duty++;
            if (32'(duty0) > 32'(peak)) peak = 32'(duty0);
            if (k == 20) begin
                check_eq("rev_duty5", 32'(duty0), 32'd5);
                led_in = 4'b0000;
            end
            if (k == 24) check_eq("rev_duty4", 32'(duty0), 32'd4);
            if (k == 40) check_eq("rev_busy_last", 32'(busy), 32'd1);
            if (k == 41) check_eq("rev_busy_drop", 32'(busy), 32'd0);
        end
        check_eq("rev_duty_seq", 32'(bad_duty), 32'd0);
        check_eq("rev_peak", 32'(peak), 32'd5);
        check_eq("rev_end_dark", 32'(led_out), 32'd0);

        // Rotation 0001 -> 0010: overlapping fall and rise.
        apply_reset(4'h0);
        led_in   = 4'b0001;
        bad_duty = 0; bad_busy = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge sys_clk);
            if (k >= 80) begin
                exp_d0 = (k < 84) ? 15 : max_i(15 - (k - 80) / 4, 0);
                exp_d1 = (k < 84) ? 0 : min_i((k - 80) / 4, 15);
                if (32'(duty0) != 32'(exp_d0) || 32'(duty1) != 32'(exp_d1)) bad_duty++;
            end
            if (k >= 61 && busy != ((k >= 82) && (k <= 140))) bad_busy++;
            if (k == 80) led_in = 4'b0010;
            if (k == 100) begin
                check_eq("rot_mid_duty0", 32'(duty0), 32'd10);
                check_eq("rot_mid_duty1", 32'(duty1), 32'd5);
                check_eq("rot_mid_busy", 32'(busy), 32'd1);
            end
        end
        check_eq("rot_duty_seq", 32'(bad_duty), 32'd0);
        check_eq("rot_busy_seq", 32'(bad_busy), 32'd0);
        check_eq("rot_final_out", 32'(led_out), 32'b0010);

        // Bypass: direct drive with one cycle latency.
        fade_en = 1'b0;
        led_in  = 4'b1010;
        @(negedge sys_clk);
        check_eq("byp_led_out", 32'(led_out), 32'b1010);
        check_eq("byp_snap_duty3", 32'(duty3), 32'd15);
        @(negedge sys_clk);
        check_eq("byp_busy", 32'(busy), 32'd0);

        // Resume fading from the snapped values, then async reset mid-fall.
        fade_en = 1'b1;
        led_in  = 4'b0000;
        repeat (10) @(negedge sys_clk);
        check_eq("resume_busy", 32'(busy), 32'd1);
        check_eq("resume_duty1", 32'(duty1), 32'd13);
        check_eq("resume_duty3", 32'(duty3), 32'd13);
        #1 sys_rst_n = 1'b0;
        #1;
        check_eq("arst_led_out", 32'(led_out), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_duty1", 32'(duty1), 32'd0);
        check_eq("arst_duty3", 32'(duty3), 32'd0);
        #1 sys_rst_n = 1'b1;
        bad_hi = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (led_out != 4'h0 || busy) bad_hi++;
        end
        check_eq("arst_no_glow", 32'(bad_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
